fb_scanout: RTL and testbench

Framebuffer scanout engine on the video-clock side of main memory. It reads packed 8-bit pixels through memory port B (word address out, 32-bit read data in, fixed 2-cycle read latency) and buffers them in a small word FIFO. It then serialises them as a valid/ready pixel stream for the HDMI pixel pipeline. It is the consumer of the memory's second (MMIO) port and runs entirely in that port's clock domain.

---
 rtl/fb_scanout.sv | 139 +++++++++++++
 tb/tb_fb_scanout.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// fb_scanout: framebuffer scanout engine on memory port B.
// Fetches packed 8-bit pixels (4 per word, little-endian) through a fixed
// 2-cycle-latency read port into a small word FIFO and serialises them as
// a valid/ready pixel stream.
// Optional feature: define FB_SCANOUT_DOUBLE_BUF_EN to add the fb_select
// input, which picks frame 0 or frame 1 at each frame_start.
module fb_scanout #(
  parameter logic [31:0] FB_BASE    = 32'h0000_C000,
  parameter int unsigned WIDTH      = 320,
  parameter int unsigned HEIGHT     = 180,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
`ifdef FB_SCANOUT_DOUBLE_BUF_EN
  input  logic        fb_select,
`endif
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [7:0]  pix_data,
  output logic        frame_done,
  output logic        underflow
);

  localparam int unsigned FRAME_WORDS = WIDTH * HEIGHT / 4;
  localparam logic [14:0] FW          = 15'(FRAME_WORDS);
  localparam int unsigned PW          = $clog2(FIFO_DEPTH);
  localparam int unsigned CW          = PW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state;
  logic [31:0]   base;
  logic [14:0]   issued;
  logic [2:0]    tag;
  logic [31:0]   fifo [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [1:0]    idx;

  logic          hs, pop, push, issue, last;
  logic [1:0]    inflight;
  logic [CW:0]   occ;
  logic [CW-1:0] count_n;
  logic [PW-1:0] rd_n;
  logic [1:0]    idx_n;
  logic [31:0]   head_n;
  logic [31:0]   base_sel;

`ifdef FB_SCANOUT_DOUBLE_BUF_EN
  assign base_sel = fb_select ? (FB_BASE + 32'(FRAME_WORDS)) : FB_BASE;
`else
  assign base_sel = FB_BASE;
`endif

  // Issue/pop decisions and next-cycle FIFO view used to register the pixel outputs.
  // tag[0] is live in the cycle mem_addr shows the address, so tag[2] marks
  // the cycle mem_rdata carries that word.
  always_comb begin
    hs       = pix_valid && pix_ready;
    pop      = hs && (idx == 2'd3);
    push     = tag[2];
    inflight = 2'(tag[0]) + 2'(tag[1]) + 2'(tag[2]);
    occ      = (CW+1)'(count) + (CW+1)'(inflight);
    issue    = (state == RUN) && (issued != FW) && (occ < (CW+1)'(FIFO_DEPTH));
    count_n  = count + CW'(push) - CW'(pop);
    rd_n     = rd_ptr + PW'(pop);
    idx_n    = idx + 2'(hs);
    // When the FIFO empties on this edge, the only possible next head is the word arriving now.
    head_n   = (count == CW'(pop)) ? mem_rdata : fifo[rd_n];
    last     = pop && (count == CW'(1)) && (tag == 3'b000) && (issued == FW);
  end

  // Word FIFO storage; stale writes after a flush are harmless because the pointers reset.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= mem_rdata;
  end

  // Scanout FSM, read issue, FIFO bookkeeping and registered pixel outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      base       <= FB_BASE;
      mem_addr   <= FB_BASE;
      issued     <= '0;
      tag        <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      idx        <= '0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_start) begin
        // Restart: flush everything and issue word 0 of the new frame right away.
        state     <= RUN;
        base      <= base_sel;
        mem_addr  <= base_sel;
        issued    <= 15'd1;
        tag       <= 3'b001;
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        count     <= '0;
        idx       <= '0;
        pix_valid <= 1'b0;
        underflow <= 1'b0;
      end else begin
        tag <= {tag[1:0], issue};
        if (issue) begin
          mem_addr <= base + 32'(issued);
          issued   <= issued + 15'd1;
        end
        rd_ptr    <= rd_n;
        wr_ptr    <= wr_ptr + PW'(push);
        count     <= count_n;
        idx       <= idx_n;
        pix_valid <= (count_n != '0);
        if (count_n != '0) pix_data <= head_n[{idx_n, 3'b000} +: 8];
        if ((state == RUN) && pix_ready && !pix_valid) underflow <= 1'b1;
        unique case (state)
          RUN:     if (issued == FW) state <= DRAIN;
          DRAIN:   if (last) begin
                     state      <= IDLE;
                     frame_done <= 1'b1;
                   end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Directed testbench for fb_scanout: a small 8x2 instance for the basic
// frame and latency, and a 32x16 instance for backpressure, underflow/abort
// and mid-frame reset. Memory is modelled as word k = {4{k[7:0]}}+32'h03020100.
module tb_fb_scanout;

  localparam logic [31:0] FB_BASE = 32'h0000_C000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fs_a, fs_b;
`ifdef FB_SCANOUT_DOUBLE_BUF_EN
  logic        fb_select;
`endif
  logic [31:0] a_addr, a_rdata, b_addr, b_rdata;
  logic        a_valid, a_ready, a_done, a_under;
  logic        b_valid, b_ready, b_done, b_under;
  logic [7:0]  a_data, b_data;
  logic [31:0] a_p1, a_p2, b_p1, b_p2;

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] img(input logic [31:0] a);
    logic [31:0] k;
    k = a - FB_BASE;
    return {4{k[7:0]}} + 32'h03020100;
  endfunction

  function automatic logic [7:0] exp_pix(input int unsigned p, input int unsigned woff);
    logic [31:0] k, w;
    k = 32'(p / 4 + woff);
    w = {4{k[7:0]}} + 32'h03020100;
    return w[8*(p%4) +: 8];
  endfunction

  // 2-cycle read latency memory models
  always @(posedge clk) begin
    a_p1 <= a_addr; a_p2 <= a_p1;
    b_p1 <= b_addr; b_p2 <= b_p1;
  end
  assign a_rdata = img(a_p2);
  assign b_rdata = img(b_p2);

  fb_scanout #(.FB_BASE(FB_BASE), .WIDTH(8), .HEIGHT(2), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .frame_start(fs_a),
`ifdef FB_SCANOUT_DOUBLE_BUF_EN
    .fb_select(fb_select),
`endif
    .mem_addr(a_addr), .mem_rdata(a_rdata), .pix_valid(a_valid), .pix_ready(a_ready),
    .pix_data(a_data), .frame_done(a_done), .underflow(a_under));

  fb_scanout #(.FB_BASE(FB_BASE), .WIDTH(32), .HEIGHT(16), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .frame_start(fs_b),
`ifdef FB_SCANOUT_DOUBLE_BUF_EN
    .fb_select(fb_select),
`endif
    .mem_addr(b_addr), .mem_rdata(b_rdata), .pix_valid(b_valid), .pix_ready(b_ready),
    .pix_data(b_data), .frame_done(b_done), .underflow(b_under));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, first, done_c, last_hs, addr_bad, issues, max_out, stab_bad, idle_bad;
    logic [31:0] max_addr, prev;
    logic fin, seen, stall_prev;
    logic [7:0] held;

    rst = 1'b1; fs_a = 1'b0; fs_b = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
`ifdef FB_SCANOUT_DOUBLE_BUF_EN
    fb_select = 1'b0;
`endif
    step(); step();
    chk("rst_addr", a_addr, FB_BASE);
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_data", 32'(a_data), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_under", 32'(a_under), 32'd0);
    rst = 1'b0;
    step();

    // Basic frame + latency (8x2): cycle 0 carries frame_start
    fs_a = 1'b1; a_ready = 1'b1;
    step(); fs_a = 1'b0;
    chk("lat_addr", a_addr, FB_BASE);
    n = 0; first = -1; done_c = -1; last_hs = -1; addr_bad = 0; max_addr = a_addr; fin = 1'b0;
    for (int c = 1; c <= 60 && !fin; c++) begin
      if (a_addr > max_addr) max_addr = a_addr;
      if (a_addr < FB_BASE || a_addr > FB_BASE + 32'd3) addr_bad++;
      if (a_valid && first < 0) begin
        first = c;
        chk("lat_first_data", 32'(a_data), 32'h00);
      end
      if (a_done) begin done_c = c; fin = 1'b1; end
      if (a_valid && a_ready) begin
        chk($sformatf("a_pix%0d", n), 32'(a_data), 32'(exp_pix(n, 0)));
        n++; last_hs = c;
      end
      if (!fin) step();
    end
    chk("lat_first_valid", 32'(first), 32'd4);
    chk("a_pixel_count", 32'(n), 32'd16);
    chk("a_done_cycle", 32'(done_c), 32'(last_hs + 1));
    chk("a_addr_range", 32'(addr_bad), 32'd0);
    chk("a_max_addr", max_addr, FB_BASE + 32'd3);
    step();
    chk("a_done_pulse", 32'(a_done), 32'd0);
    chk("a_idle_valid", 32'(a_valid), 32'd0);

    // Backpressure frame (32x16): ready 1-in-5 once the stream has started
    fs_b = 1'b1; b_ready = 1'b0;
    step(); fs_b = 1'b0;
    chk("b_first_addr", b_addr, FB_BASE);
    n = 0; issues = 1; prev = b_addr; addr_bad = 0; max_out = 0; stab_bad = 0;
    fin = 1'b0; seen = 1'b0; stall_prev = 1'b0; held = '0; done_c = -1; last_hs = -1;
    for (int c = 1; c <= 4000 && !fin; c++) begin
      if (b_addr != prev) begin
        if (b_addr != prev + 32'd1) addr_bad++;
        prev = b_addr; issues++;
      end
      if (b_addr > FB_BASE + 32'd127) addr_bad++;
      if (issues - n / 4 > max_out) max_out = issues - n / 4;
      if (b_done) begin done_c = c; fin = 1'b1; end
      if (b_valid) seen = 1'b1;
      b_ready = seen && (c % 5 == 0);
      if (stall_prev && (!b_valid || b_data != held)) stab_bad++;
      stall_prev = b_valid && !b_ready;
      held = b_data;
      if (b_valid && b_ready) begin
        chk($sformatf("b_pix%0d", n), 32'(b_data), 32'(exp_pix(n, 0)));
        n++; last_hs = c;
      end
      if (!fin) step();
    end
    chk("bp_pixel_count", 32'(n), 32'd512);
    chk("bp_issues", 32'(issues), 32'd128);
    chk("bp_addr_seq", 32'(addr_bad), 32'd0);
    chk("bp_outstanding_le_depth", 32'(max_out <= 4), 32'd1);
    chk("bp_stable", 32'(stab_bad), 32'd0);
    chk("bp_underflow", 32'(b_under), 32'd0);
    chk("bp_done_cycle", 32'(done_c), 32'(last_hs + 1));
    b_ready = 1'b0;
    step();

    // Underflow: ready held high through the startup gap, then abort mid-frame
    fs_b = 1'b1; b_ready = 1'b1;
    step(); fs_b = 1'b0;
    for (int c = 0; c < 30; c++) step();
    chk("uf_set", 32'(b_under), 32'd1);
    fs_b = 1'b1; b_ready = 1'b0;
    step(); fs_b = 1'b0;
    chk("abort_under_clr", 32'(b_under), 32'd0);
    chk("abort_valid", 32'(b_valid), 32'd0);
    chk("abort_addr", b_addr, FB_BASE);
    n = 0; first = -1;
    for (int c = 1; c <= 40 && n < 12; c++) begin
      if (b_valid) b_ready = 1'b1;
      if (b_valid && first < 0) first = c;
      if (b_valid && b_ready) begin
        chk($sformatf("abort_pix%0d", n), 32'(b_data), 32'(exp_pix(n, 0)));
        n++;
      end
      step();
    end
    chk("abort_first_valid", 32'(first), 32'd4);
    chk("abort_count", 32'(n), 32'd12);
    chk("abort_under_stays0", 32'(b_under), 32'd0);

    // Reset mid-frame at pixel 100
    b_ready = 1'b0; fs_b = 1'b1;
    step(); fs_b = 1'b0;
    n = 0;
    for (int c = 1; c <= 400 && n < 100; c++) begin
      if (b_valid) b_ready = 1'b1;
      if (b_valid && b_ready) n++;
      if (n < 100) step();
    end
    chk("rstmid_reached", 32'(n), 32'd100);
    rst = 1'b1;
    step(); rst = 1'b0;
    chk("rstmid_addr", b_addr, FB_BASE);
    chk("rstmid_valid", 32'(b_valid), 32'd0);
    chk("rstmid_data", 32'(b_data), 32'd0);
    chk("rstmid_done", 32'(b_done), 32'd0);
    chk("rstmid_under", 32'(b_under), 32'd0);
    b_ready = 1'b1; idle_bad = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (b_valid || b_addr != FB_BASE || b_under) idle_bad++;
    end
    chk("rstmid_idle", 32'(idle_bad), 32'd0);
    b_ready = 1'b0;

`ifdef FB_SCANOUT_DOUBLE_BUF_EN
    // Double buffer on the 8x2 instance: frame 1 starts at FB_BASE+4
    fb_select = 1'b1; fs_a = 1'b1; a_ready = 1'b0;
    step(); fs_a = 1'b0;
    chk("db_first_addr", a_addr, FB_BASE + 32'd4);
    max_addr = a_addr; addr_bad = 0; n = 0; fin = 1'b0;
    for (int c = 1; c <= 60 && !fin; c++) begin
      fb_select = ~fb_select;
      if (a_addr > max_addr) max_addr = a_addr;
      if (a_addr < FB_BASE + 32'd4) addr_bad++;
      if (a_done) fin = 1'b1;
      if (a_valid) a_ready = 1'b1;
      if (a_valid && a_ready) begin
        chk($sformatf("db_pix%0d", n), 32'(a_data), 32'(exp_pix(n, 4)));
        n++;
      end
      if (!fin) step();
    end
    chk("db_max_addr", max_addr, FB_BASE + 32'd7);
    chk("db_addr_low", 32'(addr_bad), 32'd0);
    chk("db_count", 32'(n), 32'd16);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
